// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer
// Drives the (a,b) sweep 00,01,10,11 into the NAND/NOR-built gate block, holds
// each vector for a settle window, samples the six gate outputs once at the end
// of that window, and keeps sticky per-gate error bits, the first failing vector
// and a saturating count of clean sweeps. Every output is a flop.
//
// In continuous mode the DONE cycle already drives vector 00, so it is counted
// as the first settle cycle of the next sweep. This keeps the done pulses
// exactly 4*(SETTLE_CYCLES+1) cycles apart, the same as the start-to-done
// latency, while every vector still sees SETTLE_CYCLES cycles of settling.

module gate_truth_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    output logic             a,
    output logic             b,
    input  logic             y_and,
    input  logic             y_or,
    input  logic             y_not,
    input  logic             y_nor,
    input  logic             y_xor,
    input  logic             y_xnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [5:0]       err_vec,
    output logic [1:0]       fail_idx,
    output logic             fail_valid,
    output logic [CNT_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t             state;
    logic [7:0]         settle_cnt;
    logic               sweep_err;

    logic [5:0]         observed;
    logic [5:0]         golden;
    logic [5:0]         mism;
    logic [5:0]         err_next;
    logic               sweep_err_next;
    logic [CNT_W-1:0]   pass_cnt_inc;

    // Gate outputs and their golden values, both ordered {xnor,xor,nor,not,or,and}
    assign observed = {y_xnor, y_xor, y_nor, y_not, y_or, y_and};
    assign golden   = {~(a ^ b), a ^ b, ~(a | b), ~a, a | b, a & b};
    assign mism     = observed ^ golden;

    // Error state as it will stand after the current sample is folded in
    assign err_next       = err_vec | mism;
    assign sweep_err_next = sweep_err | (|mism);

    // Pass counter sticks at all-ones instead of wrapping
    assign pass_cnt_inc = (&pass_cnt) ? pass_cnt : pass_cnt + CNT_W'(1);

    // Sweep controller: state, stimulus, sampling and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            sweep_err  <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_vec    <= 6'd0;
            fail_idx   <= 2'd0;
            fail_valid <= 1'b0;
            pass_cnt   <= '0;
        end else if (abort) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            sweep_err  <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    a    <= 1'b0;
                    b    <= 1'b0;
                    if (start) begin
                        state      <= SETTLE;
                        settle_cnt <= 8'd0;
                        sweep_err  <= 1'b0;
                        err_vec    <= 6'd0;
                        fail_idx   <= 2'd0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    err_vec   <= err_next;
                    sweep_err <= sweep_err_next;
                    if ((|mism) && !fail_valid) begin
                        fail_idx   <= {a, b};
                        fail_valid <= 1'b1;
                    end
                    if ({a, b} == 2'b11) begin
                        state <= DONE;
                        done  <= 1'b1;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        pass  <= (err_next == 6'd0);
                        if (!sweep_err_next) begin
                            pass_cnt <= pass_cnt_inc;
                        end
                    end else begin
                        {a, b}     <= {a, b} + 2'd1;
                        settle_cnt <= 8'd0;
                        state      <= SETTLE;
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    a    <= 1'b0;
                    b    <= 1'b0;
                    if (cont) begin
                        sweep_err <= 1'b0;
                        if (SETTLE_CYCLES == 1) begin
                            settle_cnt <= 8'd0;
                            state      <= SAMPLE;
                        end else begin
                            settle_cnt <= 8'd1;
                            state      <= SETTLE;
                        end
                    end else begin
                        settle_cnt <= 8'd0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    settle_cnt <= 8'd0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    a          <= 1'b0;
                    b          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb_gate_truth_sequencer
// Directed and randomized sweeps of gate_truth_sequencer against a fault-
// injectable gate block model and a per-sweep reference model of the results.

module tb_gate_truth_sequencer;

    localparam int S      = 4;
    localparam int CW     = 8;
    localparam int PERIOD = 4 * (S + 1);
    localparam int SAT    = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          cont;
    logic          abort;
    logic          a;
    logic          b;
    logic          y_and;
    logic          y_or;
    logic          y_not;
    logic          y_nor;
    logic          y_xor;
    logic          y_xnor;
    logic          busy;
    logic          done;
    logic          pass;
    logic [5:0]    err_vec;
    logic [1:0]    fail_idx;
    logic          fail_valid;
    logic [CW-1:0] pass_cnt;

    // Fault injection: stuck-at-0 / stuck-at-1 masks and transient glitches
    logic [5:0]    sa0;
    logic [5:0]    sa1;
    logic [5:0]    glitch;
    logic [5:0]    y_all;

    // Reference model state
    int            m_pass_cnt;
    logic [5:0]    m_err;
    logic          m_fail_valid;
    logic [1:0]    m_fail_idx;
    logic          m_pass;

    int            checks_total;
    int            checks_passed;
    int            checks_failed;

    gate_truth_sequencer #(
        .SETTLE_CYCLES(S),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .y_and     (y_and),
        .y_or      (y_or),
        .y_not     (y_not),
        .y_nor     (y_nor),
        .y_xor     (y_xor),
        .y_xnor    (y_xnor),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_vec   (err_vec),
        .fail_idx  (fail_idx),
        .fail_valid(fail_valid),
        .pass_cnt  (pass_cnt)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Golden truth table row for vector v = {a,b}, ordered {xnor,xor,nor,not,or,and}
    function automatic logic [5:0] goldenOf(input logic [1:0] v);
        logic x;
        logic y;
        x = v[1];
        y = v[0];
        return {~(x ^ y), x ^ y, ~(x | y), ~x, x | y, x & y};
    endfunction

    // Gate block with stuck-at faults applied
    function automatic logic [5:0] gateBlock(input logic [1:0] v, input logic [5:0] s0,
                                             input logic [5:0] s1);
        return (goldenOf(v) & ~s0) | s1;
    endfunction

    // Combinational gate block seen by the DUT
    assign y_all  = gateBlock({a, b}, sa0, sa1) ^ glitch;
    assign y_and  = y_all[0];
    assign y_or   = y_all[1];
    assign y_not  = y_all[2];
    assign y_nor  = y_all[3];
    assign y_xor  = y_all[4];
    assign y_xnor = y_all[5];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) begin
            checks_passed++;
        end else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic ab);
        start = s;
        cont  = c;
        abort = ab;
    endtask

    task automatic modelReset();
        m_pass_cnt   = 0;
        m_err        = 6'd0;
        m_fail_valid = 1'b0;
        m_fail_idx   = 2'd0;
        m_pass       = 1'b0;
    endtask

    task automatic modelClear();
        m_err        = 6'd0;
        m_fail_valid = 1'b0;
        m_fail_idx   = 2'd0;
        m_pass       = 1'b0;
    endtask

    // One complete sweep with fixed faults folded into the model
    task automatic modelSweep(input logic [5:0] s0, input logic [5:0] s1);
        logic       bad;
        logic [5:0] mm;
        bad = 1'b0;
        for (int v = 0; v < 4; v++) begin
            mm    = gateBlock(2'(v), s0, s1) ^ goldenOf(2'(v));
            m_err = m_err | mm;
            if (mm != 6'd0) begin
                bad = 1'b1;
                if (!m_fail_valid) begin
                    m_fail_valid = 1'b1;
                    m_fail_idx   = 2'(v);
                end
            end
        end
        m_pass = (m_err == 6'd0);
        if (!bad && m_pass_cnt < SAT) m_pass_cnt++;
    endtask

    // Runs one sweep. fresh=1 starts from IDLE; fresh=0 continues from a DONE cycle.
    // Returns at the negedge where done must be visible.
    task automatic runSweep(input logic fresh, input logic [5:0] s0, input logic [5:0] s1,
                            input int poke_k, input string tag);
        int         first_k;
        int         bad;
        logic [1:0] exp_ab;
        sa0 = s0;
        sa1 = s1;
        if (fresh) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0);
            first_k = 0;
            modelClear();
        end else begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0);
            first_k = 1;
        end
        bad = 0;
        for (int k = first_k; k < PERIOD; k++) begin
            exp_ab = 2'(k / (S + 1));
            if ({a, b} !== exp_ab || done !== 1'b0 || busy !== 1'b1) bad++;
            glitch = ((k % (S + 1)) == S) ? 6'd0 : 6'($urandom);
            start  = (k == poke_k);
            @(negedge clk);
        end
        start  = 1'b0;
        glitch = 6'd0;
        modelSweep(s0, s1);
        checkOutput({tag, "_seq_bad_cycles"}, 32'(bad), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_err_vec"}, 32'(err_vec), 32'(m_err));
        checkOutput({tag, "_fail_valid"}, 32'(fail_valid), 32'(m_fail_valid));
        checkOutput({tag, "_fail_idx"}, 32'(fail_idx), 32'(m_fail_idx));
        checkOutput({tag, "_pass"}, 32'(pass), 32'(m_pass));
        checkOutput({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(m_pass_cnt));
    endtask

    // Leave DONE with cont=0 and confirm the idle outputs
    task automatic endSweep(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_idle"}, {29'd0, busy, done, a | b}, 32'd0);
    endtask

    logic       fresh_r;
    logic [5:0] r0;
    logic [5:0] r1;
    int         done_seen;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        checks_failed = 0;
        sa0    = 6'd0;
        sa1    = 6'd0;
        glitch = 6'd0;
        rst_n  = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        modelReset();

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_outputs",
                    {10'd0, a, b, busy, done, pass, err_vec, fail_idx, fail_valid, pass_cnt},
                    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_idle", {29'd0, busy, done, a | b}, 32'd0);

        // Clean sweep
        runSweep(1'b1, 6'd0, 6'd0, -1, "t1");
        checkOutput("t1_pass_cnt_is_1", 32'(pass_cnt), 32'd1);
        endSweep("t1");

        // xor stuck-at-0
        runSweep(1'b1, 6'b010000, 6'd0, -1, "t2");
        checkOutput("t2_err_vec_direct", 32'(err_vec), 32'b010000);
        checkOutput("t2_fail_idx_direct", 32'(fail_idx), 32'b01);
        endSweep("t2");

        // Continuous mode: three clean sweeps then not stuck-at-1
        runSweep(1'b1, 6'd0, 6'd0, -1, "t3s1");
        runSweep(1'b0, 6'd0, 6'd0, -1, "t3s2");
        runSweep(1'b0, 6'd0, 6'd0, -1, "t3s3");
        runSweep(1'b0, 6'd0, 6'b000100, -1, "t3s4");
        checkOutput("t3_fail_idx_direct", 32'(fail_idx), 32'b10);
        endSweep("t3");

        // Randomized faults, randomly mixing fresh and continued sweeps
        for (int i = 0; i < 16; i++) begin
            fresh_r = (i == 0) || ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                r0 = 6'($urandom) & 6'($urandom);
                r1 = 6'($urandom) & 6'($urandom) & ~r0;
            end else begin
                r0 = 6'd0;
                r1 = 6'd0;
            end
            if (fresh_r && i != 0) endSweep("rnd");
            runSweep(fresh_r, r0, r1, -1, "rnd");
        end
        endSweep("rnd_end");

        // abort together with start in IDLE stays in IDLE
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_abort_start_idle", {29'd0, busy, done, a | b}, 32'd0);

        // start pulsed during SETTLE is ignored
        runSweep(1'b1, 6'd0, 6'd0, 2, "t4poke");
        endSweep("t4poke");

        // abort in SAMPLE of vector 10
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        modelClear();
        repeat (2 * (S + 1) + S) @(negedge clk);
        checkOutput("t4_ab_before_abort", 32'({a, b}), 32'b10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_after_abort", {29'd0, busy, done, a | b}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("t4_no_done", 32'(done_seen), 32'd0);
        checkOutput("t4_err_vec_kept", 32'(err_vec), 32'(m_err));
        checkOutput("t4_pass_kept", 32'(pass), 32'(m_pass));
        checkOutput("t4_pass_cnt_kept", 32'(pass_cnt), 32'(m_pass_cnt));

        // Asynchronous reset in the middle of SETTLE
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_reset",
                    {10'd0, a, b, busy, done, pass, err_vec, fail_idx, fail_valid, pass_cnt},
                    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        runSweep(1'b1, 6'd0, 6'd0, -1, "t5");
        checkOutput("t5_pass_cnt_is_1", 32'(pass_cnt), 32'd1);

        // 260 continuous clean sweeps saturate the counter
        runSweep(1'b0, 6'd0, 6'd0, -1, "t6");
        for (int i = 0; i < 259; i++) begin
            runSweep(1'b0, 6'd0, 6'd0, -1, "t6");
        end
        checkOutput("t6_pass_cnt_saturated", 32'(pass_cnt), 32'(SAT));
        endSweep("t6");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
